// File: rtl/crc5_pkg.sv
// rtl/crc5_pkg.sv - shared CRC-5 (x^5 + x^3 + 1) types, constants and step function
package crc5_pkg;

  localparam int CRC5_WIDTH = 5;
  localparam logic [CRC5_WIDTH-1:0] CRC5_POLY = 5'b01001;

  typedef logic [CRC5_WIDTH-1:0] crc5_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CRC     = 2'd2
  } crc5_state_t;

  // Feedback x = d ^ r[4] lands in bits 0 and 3, matching the serial generator.
  function automatic crc5_t crc5_step(crc5_t r, logic d);
    logic x;
    x = d ^ r[CRC5_WIDTH-1];
    return {r[CRC5_WIDTH-2:0], 1'b0} ^ (x ? CRC5_POLY : crc5_t'(0));
  endfunction

endpackage

// File: rtl/crc5_lfsr.sv
// rtl/crc5_lfsr.sv - serial CRC-5 LFSR with synchronous load and step enable
module crc5_lfsr
  import crc5_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load,
  input  crc5_t init,
  input  logic  en,
  input  logic  d,
  output crc5_t state
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= '0;
    end else if (load) begin
      state <= init;
    end else if (en) begin
      state <= crc5_step(state, d);
    end
  end

endmodule

// File: rtl/crc5_checker.sv
// rtl/crc5_checker.sv - serial CRC-5 frame checker; CRC5_CHECKER_ERRCNT_EN adds a saturating error counter
module crc5_checker
  import crc5_pkg::*;
#(
  parameter int          PAYLOAD_BITS = 11,
  parameter logic [4:0]  CRC_INIT     = 5'b00000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    bit_valid,
  input  logic                    bit_in,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    crc_ok,
  output logic                    crc_err,
  output logic [PAYLOAD_BITS-1:0] payload_out,
  output logic [4:0]              rx_crc,
`ifdef CRC5_CHECKER_ERRCNT_EN
  output logic [7:0]              err_count,
`endif
  output logic [4:0]              calc_crc
);

  // The counter also walks the 5 CRC bits, so it never drops below 3 bits.
  localparam int PL_CW = $clog2(PAYLOAD_BITS + 1);
  localparam int CNT_W = (PL_CW > 3) ? PL_CW : 3;

  crc5_state_t      state;
  logic [CNT_W-1:0] count;
  crc5_t            lfsr_q;
  crc5_t            lfsr_nx;
  logic             step_en;
  logic             last_pl;
  logic             last_crc;

  assign step_en  = bit_valid && !start && (state != IDLE);
  assign lfsr_nx  = crc5_step(lfsr_q, bit_in);
  assign last_pl  = step_en && (state == PAYLOAD) && (count == CNT_W'(PAYLOAD_BITS - 1));
  assign last_crc = step_en && (state == CRC) && (count == CNT_W'(CRC5_WIDTH - 1));

  crc5_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start),
    .init    (crc5_t'(CRC_INIT)),
    .en      (step_en),
    .d       (bit_in),
    .state   (lfsr_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      payload_out <= '0;
      rx_crc      <= '0;
      calc_crc    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        state   <= PAYLOAD;
        count   <= '0;
        busy    <= 1'b1;
        crc_ok  <= 1'b0;
        crc_err <= 1'b0;
      end else if (step_en) begin
        case (state)
          PAYLOAD: begin
            payload_out <= (payload_out << 1) | PAYLOAD_BITS'(bit_in);
            if (last_pl) begin
              calc_crc <= lfsr_nx;
              count    <= '0;
              state    <= CRC;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          CRC: begin
            rx_crc <= {rx_crc[3:0], bit_in};
            if (last_crc) begin
              frame_done <= 1'b1;
              crc_ok     <= (lfsr_nx == '0);
              crc_err    <= (lfsr_nx != '0);
              busy       <= 1'b0;
              count      <= '0;
              state      <= IDLE;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CRC5_CHECKER_ERRCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (last_crc && (lfsr_nx != '0) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc5_checker.sv
// tb/tb_crc5_checker.sv - scoreboard bench for crc5_checker (PAYLOAD_BITS=5); honours CRC5_CHECKER_ERRCNT_EN
module tb_crc5_checker;

  typedef struct packed {
    logic [4:0] pl;
    logic [4:0] rx;
    logic [4:0] calc;
    logic       ok;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       crc_ok;
  logic       crc_err;
  logic [4:0] payload_out;
  logic [4:0] rx_crc;
  logic [4:0] calc_crc;
`ifdef CRC5_CHECKER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   done_seen = 0;
  int   expected_done = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  crc5_checker #(.PAYLOAD_BITS(5), .CRC_INIT(5'b00000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .busy        (busy),
    .frame_done  (frame_done),
    .crc_ok      (crc_ok),
    .crc_err     (crc_err),
    .payload_out (payload_out),
    .rx_crc      (rx_crc),
`ifdef CRC5_CHECKER_ERRCNT_EN
    .err_count   (err_count),
`endif
    .calc_crc    (calc_crc)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per frame_done pulse.
  always @(negedge clk) begin
    if (reset_n && frame_done) begin
      done_seen++;
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("payload_out", payload_out, e.pl);
        chk("rx_crc", rx_crc, e.rx);
        chk("calc_crc", calc_crc, e.calc);
        chk("crc_ok", crc_ok, e.ok);
        chk("crc_err", crc_err, !e.ok);
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [4:0] pl, input logic [4:0] crc, input logic [4:0] calc,
                           input logic ok, input int gap_a, input int gap_b);
    logic [9:0] bits;
    exp_t e;
    bits = {pl, crc};
    do_start();
    chk("start_clears_ok", crc_ok, 0);
    chk("start_clears_err", crc_err, 0);
    chk("busy_after_start", busy, 1);
    e.pl = pl; e.rx = crc; e.calc = calc; e.ok = ok;
    q.push_back(e);
    expected_done++;
    for (int i = 0; i < 10; i++) begin
      send_bit(bits[9-i]);
      if (i < 9) chk("busy_mid", busy, 1);
      if (i + 1 == gap_a || i + 1 == gap_b) begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("busy_gap", busy, 1);
          chk("no_early_done", frame_done, 0);
        end
      end
    end
    chk("done_latency", frame_done, 1);
    chk("busy_clear", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse_width", frame_done, 0);
    chk("ok_held", crc_ok, ok);
    chk("err_held", crc_err, !ok);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ok", crc_ok, 0);
    chk("rst_err", crc_err, 0);
    chk("rst_payload", payload_out, 0);
    chk("rst_rx", rx_crc, 0);
    chk("rst_calc", calc_crc, 0);
`ifdef CRC5_CHECKER_ERRCNT_EN
    chk("rst_errcnt", err_count, 0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;

    // bit_valid during the start cycle must not be taken as data
    bit_valid = 1'b1; bit_in = 1'b1;
    run_frame(5'b10101, 5'b11001, 5'b11001, 1'b1, 0, 0);
    bit_valid = 1'b0;

    run_frame(5'b10101, 5'b11000, 5'b11001, 1'b0, 0, 0);
`ifdef CRC5_CHECKER_ERRCNT_EN
    chk("errcnt_one", err_count, 1);
`endif

    run_frame(5'b10101, 5'b11001, 5'b11001, 1'b1, 2, 7);

    // Aborted frame: three payload bits, then restart with a full good frame.
    do_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    run_frame(5'b10101, 5'b11001, 5'b11001, 1'b1, 0, 0);

    // Reset in the CRC phase.
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1);
    chk("busy_before_reset", busy, 1);
    chk("calc_before_reset", calc_crc, 5'b11001);
    reset_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_payload", payload_out, 0);
    chk("async_rx", rx_crc, 0);
    chk("async_calc", calc_crc, 0);
    chk("async_ok", crc_ok, 0);
    chk("async_err", crc_err, 0);
`ifdef CRC5_CHECKER_ERRCNT_EN
    chk("async_errcnt", err_count, 0);
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_frame(5'b10101, 5'b11001, 5'b11001, 1'b1, 0, 0);
    run_frame(5'b11111, 5'b10001, 5'b10001, 1'b1, 4, 0);
    run_frame(5'b11111, 5'b10011, 5'b10001, 1'b0, 0, 0);

`ifdef CRC5_CHECKER_ERRCNT_EN
    chk("errcnt_after_reset", err_count, 1);
    for (int n = 0; n < 260; n++) begin
      run_frame(5'b10101, 5'b11000, 5'b11001, 1'b0, 0, 0);
    end
    chk("errcnt_saturate", err_count, 255);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_seen, expected_done);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
